reconcat_rd_stream: RTL and testbench

- Streaming successor to the fixed-format DDR read re-concatenation stage.
- Accepts wide DDR read words of tightly packed pixels (runtime bytes-per-pixel). Pixels may straddle word boundaries.
- Unpacks them into per-port three-component pixels at a runtime BPC, with valid/ready on both sides and frame resync on VS.
- Sits between the frame-buffer read DMA and the video timing/output stage.

---
 rtl/reconcat_rd_stream.sv | 171 +++++++++++++++++
 tb/tb_reconcat_rd_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reconcat_rd_stream.sv
// Unpacks tightly packed DDR read words into per-port three-component pixels.
// Runtime bytes-per-pixel, bits-per-component and port count are latched on each VS rising edge.
module reconcat_rd_stream #(
  parameter int C_IN_BYTES               = 16,
  parameter int C_MAX_PORT_NUM           = 2,
  parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 8,
  parameter int C_MAX_BPC                = 16
) (
  input  logic                                  CLK_I,
  input  logic                                  RST_I,
  input  logic                                  PIXEL_VS_I,
  input  logic [7:0]                            CFG_DDR_BYTE_NUM_I,
  input  logic [4:0]                            CFG_BPC_I,
  input  logic [7:0]                            CFG_PORT_NUM_I,
  input  logic [C_IN_BYTES*8-1:0]               DATA_I,
  input  logic                                  VALID_I,
  output logic                                  READY_O,
  output logic [C_MAX_BPC*3*C_MAX_PORT_NUM-1:0] PIXEL_DATA_O,
  output logic                                  PIXEL_VALID_O,
  input  logic                                  PIXEL_READY_I,
  output logic                                  PIXEL_SOF_O,
  output logic                                  ERR_CFG_O
);

  localparam int ST_BYTES = 2 * C_IN_BYTES;
  localparam int LW       = $clog2(ST_BYTES + 1);
  localparam int PIX_BITS = 3 * C_MAX_BPC;
  localparam int WIN_BITS = 8 * C_DDR_PIXEL_MAX_BYTE_NUM;

  if (C_DDR_PIXEL_MAX_BYTE_NUM * C_MAX_PORT_NUM > C_IN_BYTES) begin : g_bad_params
    $error("reconcat_rd_stream: C_DDR_PIXEL_MAX_BYTE_NUM*C_MAX_PORT_NUM exceeds C_IN_BYTES");
  end

  function automatic logic cfg_legal(input logic [7:0] b, input logic [4:0] bpc, input logic [7:0] p);
    logic bpc_ok;
    bpc_ok = ((bpc == 5'd6) || (bpc == 5'd8) || (bpc == 5'd10) || (bpc == 5'd12) || (bpc == 5'd16))
             && (int'(bpc) <= C_MAX_BPC);
    return (b >= 8'd1) && (int'(b) <= C_DDR_PIXEL_MAX_BYTE_NUM) && (p >= 8'd1)
           && (int'(p) <= C_MAX_PORT_NUM) && bpc_ok && ((16'(bpc) * 16'd3) <= (16'(b) * 16'd8));
  endfunction

  logic                                  vs_d_r;
  logic [7:0]                            cfg_b_r;
  logic [4:0]                            cfg_bpc_r;
  logic [7:0]                            cfg_p_r;
  logic                                  err_r;
  logic [LW-1:0]                         level_r;
  logic [ST_BYTES*8-1:0]                 store_r;
  logic                                  valid_r;
  logic                                  sof_r;
  logic                                  sof_pend_r;
  logic [PIX_BITS*C_MAX_PORT_NUM-1:0]    data_r;

  logic                                  vs_rise_s;
  logic                                  ready_s;
  logic                                  in_fire_s;
  logic                                  load_s;
  logic [15:0]                           bp_s;
  logic [15:0]                           lvl_ext_s;
  logic [15:0]                           deq_s;
  logic [15:0]                           base_s;
  logic [15:0]                           lvl_nxt_s;
  logic [ST_BYTES*8-1:0]                 shifted_s;
  logic [ST_BYTES*8-1:0]                 store_nxt_s;
  logic [C_MAX_BPC:0]                    mask_full_s;
  logic [C_MAX_BPC-1:0]                  mask_s;
  logic [PIX_BITS*C_MAX_PORT_NUM-1:0]    pix_nxt_s;

  assign vs_rise_s   = PIXEL_VS_I & ~vs_d_r;
  assign bp_s        = 16'(cfg_b_r) * 16'(cfg_p_r);
  assign lvl_ext_s   = 16'(level_r);
  assign ready_s     = !RST_I && !err_r && !vs_rise_s && (lvl_ext_s <= 16'(C_IN_BYTES));
  assign in_fire_s   = VALID_I & ready_s;
  assign load_s      = (!valid_r || PIXEL_READY_I) && (lvl_ext_s >= bp_s) && !err_r && !vs_rise_s;
  assign deq_s       = load_s ? bp_s : 16'd0;
  assign base_s      = lvl_ext_s - deq_s;
  assign lvl_nxt_s   = base_s + (in_fire_s ? 16'(C_IN_BYTES) : 16'd0);
  assign shifted_s   = store_r >> {deq_s, 3'b000};
  assign mask_full_s = ({{C_MAX_BPC{1'b0}}, 1'b1} << cfg_bpc_r) - {{C_MAX_BPC{1'b0}}, 1'b1};
  assign mask_s      = mask_full_s[C_MAX_BPC-1:0];

  // Next byte store: dequeue shift first, then append the input word behind the remaining bytes.
  always_comb begin
    store_nxt_s = shifted_s;
    if (in_fire_s) begin
      for (int i = 0; i < C_IN_BYTES; i++) begin
        store_nxt_s[(int'(base_s) + i) * 8 +: 8] = DATA_I[i*8 +: 8];
      end
    end else begin
      store_nxt_s = shifted_s;
    end
  end

  // Unpack the head of the store; components stay inside B bytes because 3*BPC <= 8*B.
  always_comb begin
    logic [ST_BYTES*8-1:0] full_v;
    logic [WIN_BITS-1:0]   win_v;
    logic [WIN_BITS-1:0]   part_v;
    full_v    = '0;
    win_v     = '0;
    part_v    = '0;
    pix_nxt_s = '0;
    for (int k = 0; k < C_MAX_PORT_NUM; k++) begin
      if (k < int'(cfg_p_r)) begin
        full_v = store_r >> (k * int'(cfg_b_r) * 8);
        win_v  = full_v[WIN_BITS-1:0];
        for (int c = 0; c < 3; c++) begin
          part_v = win_v >> (c * int'(cfg_bpc_r));
          pix_nxt_s[k*PIX_BITS + c*C_MAX_BPC +: C_MAX_BPC] = part_v[C_MAX_BPC-1:0] & mask_s;
        end
      end else begin
        pix_nxt_s[k*PIX_BITS +: PIX_BITS] = '0;
      end
    end
  end

  // VS edge detect, configuration latch and error flag.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      vs_d_r    <= 1'b0;
      cfg_b_r   <= 8'd3;
      cfg_bpc_r <= 5'd8;
      cfg_p_r   <= 8'(C_MAX_PORT_NUM);
      err_r     <= 1'b0;
    end else begin
      vs_d_r <= PIXEL_VS_I;
      if (vs_rise_s) begin
        cfg_b_r   <= CFG_DDR_BYTE_NUM_I;
        cfg_bpc_r <= CFG_BPC_I;
        cfg_p_r   <= CFG_PORT_NUM_I;
        err_r     <= !cfg_legal(CFG_DDR_BYTE_NUM_I, CFG_BPC_I, CFG_PORT_NUM_I);
      end
    end
  end

  // Byte store, level and output beat register; a VS edge flushes everything in flight.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      level_r    <= '0;
      store_r    <= '0;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      sof_pend_r <= 1'b1;
      data_r     <= '0;
    end else if (vs_rise_s) begin
      level_r    <= '0;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      sof_pend_r <= 1'b1;
    end else begin
      level_r <= lvl_nxt_s[LW-1:0];
      store_r <= store_nxt_s;
      if (load_s) begin
        valid_r    <= 1'b1;
        data_r     <= pix_nxt_s;
        sof_r      <= sof_pend_r;
        sof_pend_r <= 1'b0;
      end else if (PIXEL_READY_I) begin
        valid_r <= 1'b0;
        sof_r   <= 1'b0;
      end
    end
  end

  assign READY_O       = ready_s;
  assign PIXEL_VALID_O = valid_r;
  assign PIXEL_DATA_O  = data_r;
  assign PIXEL_SOF_O   = sof_r;
  assign ERR_CFG_O     = err_r;

endmodule

// File: tb/tb_reconcat_rd_stream.sv
// Directed + randomized bench for reconcat_rd_stream against a byte-queue reference model.
module tb_reconcat_rd_stream;
  localparam int IN    = 16;
  localparam int PORTS = 2;
  localparam int MAXB  = 8;
  localparam int MBPC  = 16;
  localparam int PW    = 3 * MBPC;

  logic         clk = 1'b0;
  logic         rst;
  logic         vs;
  logic [7:0]   cfg_b;
  logic [4:0]   cfg_bpc;
  logic [7:0]   cfg_p;
  logic [127:0] data;
  logic         valid;
  logic         ready_o;
  logic [95:0]  pdata;
  logic         pvalid;
  logic         pready;
  logic         sof;
  logic         err;

  reconcat_rd_stream dut (
    .CLK_I(clk), .RST_I(rst), .PIXEL_VS_I(vs), .CFG_DDR_BYTE_NUM_I(cfg_b), .CFG_BPC_I(cfg_bpc),
    .CFG_PORT_NUM_I(cfg_p), .DATA_I(data), .VALID_I(valid), .READY_O(ready_o),
    .PIXEL_DATA_O(pdata), .PIXEL_VALID_O(pvalid), .PIXEL_READY_I(pready),
    .PIXEL_SOF_O(sof), .ERR_CFG_O(err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes accepted since the last flush and not yet delivered in a beat.
  byte unsigned q[$];
  logic [95:0]  beats[$];
  int           m_b = 3, m_bpc = 8, m_p = 2;
  bit           m_err = 1'b0, m_sof = 1'b1, vs_prev = 1'b0, hold = 1'b0;
  logic [95:0]  held_data;
  logic         held_sof;
  int           checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int b, input int bpc, input int p);
    return (b >= 1) && (b <= MAXB) && (p >= 1) && (p <= PORTS) && (bpc <= MBPC) &&
           (bpc == 6 || bpc == 8 || bpc == 10 || bpc == 12 || bpc == 16) && (3 * bpc <= 8 * b);
  endfunction

  function automatic int model_level();
    return q.size() - (pvalid ? m_b * m_p : 0);
  endfunction

  task automatic sample();
    int               lvl;
    bit               rise;
    logic [95:0]      exp;
    longint unsigned  v, mask, part;
    rise = vs && !vs_prev;
    lvl  = model_level();
    chk("ready", ready_o, (!m_err && !rise && lvl <= IN));
    chk("err", err, m_err);
    chk("level", dut.level_r, lvl);
    chk("level_max", (dut.level_r <= 2 * IN), 1'b1);
    if (m_err) chk("no_beat_in_err", pvalid, 1'b0);
    if (hold && pvalid) begin
      chk("hold_data", pdata, held_data);
      chk("hold_sof", sof, held_sof);
    end
    if (pvalid && pready) begin
      if (q.size() < m_b * m_p) begin
        chk("beat_underflow", q.size(), m_b * m_p);
      end else begin
        exp  = '0;
        mask = (64'd1 << m_bpc) - 64'd1;
        for (int k = 0; k < m_p; k++) begin
          v = 0;
          for (int j = 0; j < m_b; j++) v |= longint'(q.pop_front()) << (8 * j);
          for (int c = 0; c < 3; c++) begin
            part = (v >> (c * m_bpc)) & mask;
            exp[k*PW + c*MBPC +: MBPC] = part[15:0];
          end
        end
        chk("beat_data", pdata, exp);
        chk("beat_sof", sof, m_sof);
        m_sof = 1'b0;
        beats.push_back(pdata);
      end
    end
    hold      = pvalid && !pready;
    held_data = pdata;
    held_sof  = sof;
    if (valid && ready_o) for (int i = 0; i < IN; i++) q.push_back(data[i*8 +: 8]);
    if (rise) begin
      q.delete();
      beats.delete();
      m_b   = int'(cfg_b);
      m_bpc = int'(cfg_bpc);
      m_p   = int'(cfg_p);
      m_err = !legal(m_b, m_bpc, m_p);
      m_sof = 1'b1;
      hold  = 1'b0;
    end
    vs_prev = vs;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [127:0] w);
    bit fired;
    fired = 1'b0;
    data  = w;
    valid = 1'b1;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clk);
      fired = ready_o;
      sample();
      @(posedge clk);
      #1;
    end
    chk("send_timeout", fired, 1'b1);
    valid = 1'b0;
  endtask

  task automatic vs_pulse(input int b, input int bpc, input int p);
    cfg_b   = 8'(b);
    cfg_bpc = 5'(bpc);
    cfg_p   = 8'(p);
    vs      = 1'b1;
    step();
    vs = 1'b0;
    step();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] w;
    rst = 1'b1; vs = 1'b0; valid = 1'b0; pready = 1'b1; data = '0;
    cfg_b = 8'd3; cfg_bpc = 5'd8; cfg_p = 8'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_valid", pvalid, 1'b0);
    chk("rst_data", pdata, 96'h0);
    chk("rst_sof", sof, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_level", dut.level_r, 0);
    rst = 1'b0;
    step();

    // B=5 BPC=8 P=2, single known word
    vs_pulse(5, 8, 2);
    send_word(128'h000000000000_ffddccbbaa5544332211);
    repeat (4) step();
    chk("s1_beats", beats.size(), 1);
    chk("s1_port0", beats[0][47:0], 48'h0033_0022_0011);
    chk("s1_port1", beats[0][95:48], 48'h00cc_00bb_00aa);
    chk("s1_level", dut.level_r, 6);

    // B=3 straddling pixels, incrementing bytes
    vs_pulse(3, 8, 2);
    for (int wi = 0; wi < 4; wi++) begin
      for (int i = 0; i < IN; i++) w[i*8 +: 8] = 8'(wi * IN + i);
      send_word(w);
    end
    repeat (20) step();
    chk("s2_beats", beats.size(), 10);
    chk("s2_first", beats[0], 96'h0005_0004_0003_0002_0001_0000);
    chk("s2_straddle", beats[2][95:48], 48'h0011_0010_000f);

    // backpressure then random traffic
    vs_pulse(3, 8, 2);
    pready = 1'b0;
    valid  = 1'b1;
    for (int n = 0; n < 10; n++) begin data = rand_word(); step(); end
    chk("s3_ready_low", ready_o, 1'b0);
    chk("s3_valid_held", pvalid, 1'b1);
    for (int n = 0; n < 60; n++) begin
      data   = rand_word();
      valid  = 1'($urandom_range(0, 1));
      pready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    valid = 1'b0; pready = 1'b1;
    repeat (30) step();
    chk("s3_residual", dut.level_r, q.size());

    // BPC=10 with padding bits, single port
    vs_pulse(4, 10, 1);
    send_word(128'hc00003ff_c00003ff_c00003ff_c00003ff);
    repeat (8) step();
    chk("s4_beats", beats.size(), 4);
    chk("s4_beat", beats[0], 96'h0000_0000_03ff);

    // VS flush with level 7
    vs_pulse(3, 8, 1);
    send_word(rand_word());
    for (int n = 0; n < 20 && model_level() != 7; n++) step();
    chk("s5_level7", dut.level_r, 7);
    vs = 1'b1; valid = 1'b1; data = rand_word();
    #1;
    chk("s5_ready_vs", ready_o, 1'b0);
    step();
    vs = 1'b0; valid = 1'b0;
    chk("s5_valid_flushed", pvalid, 1'b0);
    send_word(128'h0f0e0d0c0b0a090807060504_03a3a2a1);
    repeat (10) step();
    chk("s5_first", beats[0], 96'h00a3_00a2_00a1);

    // illegal config, then recovery
    vs_pulse(2, 12, 2);
    valid = 1'b1; data = rand_word();
    repeat (5) step();
    valid = 1'b0;
    chk("s6_err", err, 1'b1);
    chk("s6_ready", ready_o, 1'b0);
    chk("s6_no_beats", beats.size(), 0);
    vs_pulse(3, 8, 2);
    send_word(rand_word());
    send_word(rand_word());
    repeat (12) step();
    chk("s6_err_clear", err, 1'b0);
    chk("s6_beats", beats.size(), 5);

    // asynchronous reset mid-stream
    send_word(rand_word());
    rst = 1'b1;
    #1;
    chk("s7_valid", pvalid, 1'b0);
    chk("s7_ready", ready_o, 1'b0);
    chk("s7_level", dut.level_r, 0);
    chk("s7_data", pdata, 96'h0);
    q.delete(); beats.delete();
    m_b = 3; m_bpc = 8; m_p = 2; m_err = 1'b0; m_sof = 1'b1; hold = 1'b0; vs_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(rand_word());
    repeat (6) step();
    chk("s7_beats", beats.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
